object_bitmap_reader: RTL
=========================

OBJECT_BITMAP_READER -- requirements
Module: object_bitmap_reader

Interface
REQ-001 The module SHALL expose these parameters, one per line: name, default, meaning.
- TRANSPARENT, 8'hFF: pixel value that never produces a draw.
- FRAMES_PER_STEP, 6: startOfFrame pulses per animation step; legal range 1..63.
- TEST_PATTERN, 0: 1 selects the built-in verification ROM content.

REQ-002 The module SHALL have these ports, one per line: name, direction, width, meaning. Clock and reset are listed first.
- clk, in, 1: clock.
- resetN, in, 1: reset, asynchronous, active-low.
- offset_x, in, 11: pixel column relative to the object's top-left corner; source is the upstream draw/offset mux.
- offset_y, in, 11: pixel row relative to the object's top-left corner.
- drawRequestIn, in, 1: the current pixel lies inside the object's rectangle.
- startOfFrame, in, 1: one-cycle pulse at the start of each video frame.
- animEnable, in, 1: 1 lets the animation advance.
- syncFrameReset, in, 1: synchronous return to animation frame 0.
- flipH, in, 1: mirror the sprite horizontally.
- RGBout, out, 8: pixel colour, RRRGGGBB.
- drawingRequest, out, 1: the pixel is opaque and must be drawn.
- animFrame, out, 2: current animation frame index.

Function
REQ-003 Sprite storage SHALL be a read-only table of 4 frames x 32 rows x 32 columns x 8 bits, addressed as {frame[1:0], row[4:0], col[4:0]}.
REQ-004 When TEST_PATTERN=1, each table entry SHALL equal {frame[1:0], row[2:0], col[2:0]}.
REQ-005 When TEST_PATTERN=0, table content SHALL come from the team sprite initialisation table.
REQ-006 A pixel SHALL be in range only when offset_x < 32 and offset_y < 32; both tests are unsigned on the full 11 bits.
REQ-007 Column SHALL be offset_x[4:0] when flipH=0, and 31 - offset_x[4:0] when flipH=1. Row SHALL be offset_y[4:0].
REQ-008 Stage 1 SHALL register the table address and v1 = drawRequestIn AND in-range, using the animFrame value current on that cycle.
REQ-009 Stage 2 SHALL register the table data at the stage-1 address, together with v2 = v1.
REQ-010 Output rules:
- drawingRequest SHALL equal v2 AND (data != TRANSPARENT).
- RGBout SHALL equal data when drawingRequest=1, else 8'h00.
REQ-011 Total latency from drawRequestIn/offsets to RGBout/drawingRequest SHALL be exactly 2 clk cycles, fully pipelined, accepting a new pixel every cycle with no stalls.
REQ-012 An out-of-range pixel, or a pixel with drawRequestIn=0, SHALL yield drawingRequest=0 and RGBout=8'h00 two cycles later.
REQ-013 Animation SHALL use a 6-bit pulse counter divCnt and the 2-bit animFrame register. Both SHALL change only on cycles where startOfFrame=1 or syncFrameReset=1.
REQ-014 On startOfFrame=1 with animEnable=1:
- if divCnt = FRAMES_PER_STEP-1, divCnt SHALL go to 0 and animFrame SHALL increment modulo 4 (3 wraps to 0);
- otherwise divCnt SHALL increment.
REQ-015 On startOfFrame=1 with animEnable=0, divCnt and animFrame SHALL hold.
REQ-016 syncFrameReset=1 SHALL clear divCnt and animFrame on that clock edge. It has priority over a simultaneous startOfFrame.
REQ-017 A change of animFrame SHALL affect only pixels entering stage 1 after the update edge; pixels already in the pipeline complete with their captured frame.
REQ-018 When FRAMES_PER_STEP=1, animFrame SHALL advance on every enabled startOfFrame pulse.

Reset
REQ-019 While resetN=0, the following SHALL be forced to 0 immediately, independent of clk: RGBout=8'h00, drawingRequest, animFrame, divCnt, v1, v2, and the stage-1 address.
REQ-020 After resetN is released, the first valid output SHALL appear 2 cycles after the first drawRequestIn=1. Reset mid-stream SHALL discard all in-flight pixels.

Verification
REQ-021 The bench SHALL run with TEST_PATTERN=1 and FRAMES_PER_STEP=2, and SHALL cover these directed scenarios:
- Basic read and latency: frame 0, offset (5,3), drawRequestIn=1, flipH=0 -> two cycles later RGBout=8'h1D, drawingRequest=1.
- Horizontal flip: offset (5,3), flipH=1 (col 26) -> RGBout=8'h1A. Range check: offset (32,0) with drawRequestIn=1 -> drawingRequest=0, RGBout=8'h00.
- Animation divider: animEnable=1, four startOfFrame pulses -> animFrame goes 0,1,1,2 after pulses 1..4 (changes on pulses 2 and 4). After four more pulses animFrame=0 (wrap from 3).
- Transparency: force animFrame=3 by stepping, then offset (7,7) -> table value 8'hFF, so drawingRequest=0 and RGBout=8'h00. Offset (6,7) -> RGBout=8'hFE.
- Priority and hold: syncFrameReset and startOfFrame asserted together at animFrame=2 -> animFrame=0, divCnt=0. animEnable=0 with pulses -> animFrame holds.
- Back-to-back pixels and reset: streaming offsets x=0..31 -> one output per cycle, 2-cycle delay, no gaps. resetN pulse mid-stream -> outputs 0 immediately, stale pixels never emitted.

Source files
------------

// File: rtl/object_bitmap_reader.sv
// Two-stage sprite bitmap reader: maps an object-relative pixel offset to a colour
// from a 4-frame 32x32 table, with a startOfFrame-driven animation frame counter.
module object_bitmap_reader #(
  parameter logic [7:0] TRANSPARENT     = 8'hFF,
  parameter int         FRAMES_PER_STEP = 6,
  parameter bit         TEST_PATTERN    = 1'b0
) (
  input  logic        clk,
  input  logic        resetN,
  input  logic [10:0] offset_x,
  input  logic [10:0] offset_y,
  input  logic        drawRequestIn,
  input  logic        startOfFrame,
  input  logic        animEnable,
  input  logic        syncFrameReset,
  input  logic        flipH,
  output logic [7:0]  RGBout,
  output logic        drawingRequest,
  output logic [1:0]  animFrame
);

  localparam logic [5:0] DIV_LAST = 6'(FRAMES_PER_STEP - 1);

  logic [1:0]  r_animFrame;
  logic [5:0]  r_divCnt;
  logic [11:0] r_addr_p1;
  logic        r_vld_p1;
  logic [7:0]  r_data_p2;
  logic        r_vld_p2;

  logic        w_in_range;
  logic [4:0]  w_col;
  logic [11:0] w_addr;
  logic        w_draw;

  // Table content: either the verification pattern or the default sprite, a disc
  // whose colour encodes frame, row band and column band; corners are transparent.
  function automatic logic [7:0] rom_read(input logic [11:0] a);
    logic [1:0]         fr;
    logic [4:0]         row;
    logic [4:0]         col;
    logic signed [13:0] dx;
    logic signed [13:0] dy;
    logic signed [13:0] r2;
    fr  = a[11:10];
    row = a[9:5];
    col = a[4:0];
    dx  = $signed({8'd0, col, 1'b0}) - 14'sd31;
    dy  = $signed({8'd0, row, 1'b0}) - 14'sd31;
    r2  = dx * dx + dy * dy;
    if (TEST_PATTERN)
      rom_read = {fr, row[2:0], col[2:0]};
    else if (r2 < 14'sd900)
      rom_read = {fr, 1'b1, row[4:2], col[4:3]};
    else
      rom_read = TRANSPARENT;
  endfunction

  assign w_in_range = (offset_x < 11'd32) && (offset_y < 11'd32);
  assign w_col      = flipH ? (5'd31 - offset_x[4:0]) : offset_x[4:0];
  assign w_addr     = {r_animFrame, offset_y[4:0], w_col};

  // Animation divider: only startOfFrame or syncFrameReset cycles change state
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      r_divCnt    <= 6'd0;
      r_animFrame <= 2'd0;
    end else if (syncFrameReset) begin
      r_divCnt    <= 6'd0;
      r_animFrame <= 2'd0;
    end else if (startOfFrame && animEnable) begin
      if (r_divCnt == DIV_LAST) begin
        r_divCnt    <= 6'd0;
        r_animFrame <= r_animFrame + 2'd1;
      end else begin
        r_divCnt <= r_divCnt + 6'd1;
      end
    end
  end

  // Stage 1: address capture with the frame current on this cycle
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      r_addr_p1 <= 12'd0;
      r_vld_p1  <= 1'b0;
      r_vld_p2  <= 1'b0;
    end else begin
      r_addr_p1 <= w_addr;
      r_vld_p1  <= drawRequestIn && w_in_range;
      r_vld_p2  <= r_vld_p1;
    end
  end

  // Stage 2: table read; outputs are gated by the reset-cleared valid
  always_ff @(posedge clk) begin
    r_data_p2 <= rom_read(r_addr_p1);
  end

  assign w_draw         = r_vld_p2 && (r_data_p2 != TRANSPARENT);
  assign drawingRequest = w_draw;
  assign RGBout         = w_draw ? r_data_p2 : 8'h00;
  assign animFrame      = r_animFrame;

endmodule
